// File: rtl/fpcvt_arbiter.sv
// fpcvt_arbiter: round-robin sharing of one combinational FPCVT converter among NREQ requesters.
// Optional macro FPCVT_STATS_EN adds sat_count, a saturating count of full-scale results.
module fpcvt_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 3
) (
   input  logic                clk,
   input  logic                rst,
`ifdef FPCVT_STATS_EN
   output logic [15:0]         sat_count,
`endif
   input  logic [NREQ-1:0]     req_valid,
   input  logic [12*NREQ-1:0]  req_data,
   output logic [NREQ-1:0]     req_ready,
   output logic [11:0]         cvt_d,
   input  logic                cvt_s,
   input  logic [2:0]          cvt_e,
   input  logic [3:0]          cvt_f,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [IDW-1:0]      out_id,
   output logic                out_s,
   output logic [2:0]          out_e,
   output logic [3:0]          out_f
);
   localparam int PW = $clog2(NREQ);
   typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;
   state_t          state_q, state_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d, gnt_idx;
   logic [PW:0]     k;
   logic            found, accept_ok, xfer;
   logic [11:0]     cvt_q;
   logic [IDW-1:0]  id_q, out_id_q;
   logic            out_valid_q, out_s_q;
   logic [2:0]      out_e_q;
   logic [3:0]      out_f_q;
   // scan upward from rr_ptr, wrapping modulo NREQ
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      k       = '0;
      for (int i = 0; i < NREQ; i++) begin
         k = {1'b0, rr_ptr_q} + (PW+1)'(i);
         k = (k >= (PW+1)'(NREQ)) ? k - (PW+1)'(NREQ) : k;
         if (!found && req_valid[k[PW-1:0]]) begin
            found   = 1'b1;
            gnt_idx = k[PW-1:0];
         end
      end
   end
   assign accept_ok = (state_q == IDLE) || (state_q == HOLD && out_ready);
   assign req_ready = (accept_ok && found && !rst) ? NREQ'(1) << gnt_idx : '0;
   assign xfer      = |(req_valid & req_ready);
   assign rr_ptr_d  = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
   always_comb begin
      state_d = state_q;
      state_d = (state_q == CONV) ? HOLD :
                (state_q == HOLD && !out_ready) ? HOLD :
                xfer ? CONV : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         cvt_q       <= '0;
         id_q        <= '0;
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         out_s_q     <= 1'b0;
         out_e_q     <= '0;
         out_f_q     <= '0;
      end else begin
         state_q <= state_d;
         if (xfer) begin
            cvt_q    <= req_data[12*int'(gnt_idx) +: 12];
            id_q     <= IDW'(gnt_idx);
            rr_ptr_q <= rr_ptr_d;
         end
         if (state_q == CONV) begin
            out_s_q     <= cvt_s;
            out_e_q     <= cvt_e;
            out_f_q     <= cvt_f;
            out_id_q    <= id_q;
            out_valid_q <= 1'b1;
         end else if (state_q == HOLD && out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end
   assign cvt_d     = cvt_q;
   assign out_valid = out_valid_q;
   assign out_id    = out_id_q;
   assign out_s     = out_s_q;
   assign out_e     = out_e_q;
   assign out_f     = out_f_q;
`ifdef FPCVT_STATS_EN
   logic [15:0] sat_q;
   always_ff @(posedge clk) begin
      if (rst) sat_q <= '0;
      else if (state_q == CONV && cvt_e == 3'b111 && cvt_f == 4'hF && sat_q != 16'hFFFF)
         sat_q <= sat_q + 16'd1;
   end
   assign sat_count = sat_q;
`endif
endmodule

// File: tb/tb_fpcvt_arbiter.sv
// tb_fpcvt_arbiter: directed stimulus with a queue-level reference model checked every cycle.
module tb_fpcvt_arbiter;
   localparam int N = 4;
   logic          clk = 1'b0, rst = 1'b1;
   logic [N-1:0]  req_valid = '0;
   logic [12*N-1:0] req_data = '0;
   logic [N-1:0]  req_ready;
   logic [11:0]   cvt_d;
   logic          cvt_s;
   logic [2:0]    cvt_e;
   logic [3:0]    cvt_f;
   logic          out_valid, out_ready = 1'b0;
   logic [2:0]    out_id;
   logic          out_s;
   logic [2:0]    out_e;
   logic [3:0]    out_f;
`ifdef FPCVT_STATS_EN
   logic [15:0]   sat_count;
   int            m_sat = 0;
`endif
   int n_chk = 0, n_err = 0;
   always #5 clk = ~clk;

   fpcvt_arbiter #(.NREQ(N), .IDW(3)) dut (
      .clk(clk), .rst(rst),
`ifdef FPCVT_STATS_EN
      .sat_count(sat_count),
`endif
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .cvt_d(cvt_d), .cvt_s(cvt_s), .cvt_e(cvt_e), .cvt_f(cvt_f),
      .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
      .out_s(out_s), .out_e(out_e), .out_f(out_f));

   // shared converter: value = F * 2^E, truncating, saturating at E=7/F=15
   function automatic logic [7:0] cv(input logic [11:0] d);
      logic [11:0] m;
      int p;
      if (d == 12'h800) return {1'b1, 3'd7, 4'hF};
      m = d[11] ? -d : d;
      p = 0;
      for (int i = 0; i < 12; i++) if (m[i]) p = i;
      if (p <= 3) return {d[11], 3'd0, m[3:0]};
      return {d[11], 3'(p - 3), 4'(m >> (p - 3))};
   endfunction
   assign {cvt_s, cvt_e, cvt_f} = cv(cvt_d);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: one in-flight result, visible two edges after its transfer
   logic       hp = 1'b0;
   int         age = 0, ptr = 0, p_id = 0, m_id = 0;
   logic [7:0] p_cv = '0, m_cv = '0;
   logic [11:0] m_d = '0;
   always @(negedge clk) begin
      logic ov, acc;
      logic [N-1:0] er;
      int g;
      ov  = hp && age >= 2;
      acc = !rst && (!hp || (ov && out_ready));
      g = -1;
      for (int i = 0; i < N; i++) if (g < 0 && req_valid[(ptr + i) % N]) g = (ptr + i) % N;
      er = (acc && g >= 0) ? N'(1) << g : '0;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("out_valid", 32'(out_valid), 32'(ov));
      chk("out_id", 32'(out_id), m_id);
      chk("out_sef", {out_s, out_e, out_f}, 32'(m_cv));
      chk("cvt_d", 32'(cvt_d), 32'(m_d));
`ifdef FPCVT_STATS_EN
      chk("sat_count", 32'(sat_count), m_sat);
`endif
      if (rst) begin
         hp = 0; ptr = 0; m_id = 0; m_cv = '0; m_d = '0;
`ifdef FPCVT_STATS_EN
         m_sat = 0;
`endif
      end else begin
         if (ov && out_ready) hp = 0;
         if (hp && age == 1) begin
            m_id = p_id; m_cv = p_cv;
`ifdef FPCVT_STATS_EN
            if (p_cv[6:0] == 7'h7F && m_sat < 65535) m_sat++;
`endif
         end
         if (hp) age++;
         if (|(er & req_valid)) begin
            hp = 1; age = 1; p_id = g; ptr = (g + 1) % N;
            m_d = req_data[g*12 +: 12]; p_cv = cv(m_d);
         end
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic single(input int k, input logic [11:0] d, input logic [7:0] exp);
      req_valid[k] = 1'b1; req_data[k*12 +: 12] = d;
      step();
      req_valid[k] = 1'b0;
      step();
      chk("single_valid", 32'(out_valid), 1);
      chk("single_id", 32'(out_id), k);
      chk("single_sef", {out_s, out_e, out_f}, 32'(exp));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("single_retire", 32'(out_valid), 0);
   endtask

   initial begin
      int ids[$];
      int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
      chk("cv_800", cv(12'h800), 8'hFF);
      chk("cv_422", cv(12'd422), {1'b0, 3'd5, 4'b1101});
      chk("cv_7ff", cv(12'h7FF), 8'h7F);
      step(2);
      chk("rst_valid", 32'(out_valid), 0);
      rst = 1'b0;
      single(0, 12'h000, 8'h00);
      single(1, 12'h800, 8'hFF);
      single(2, 12'd422, {1'b0, 3'd5, 4'b1101});
      single(3, 12'h7FF, 8'h7F);
      // round robin, all valid and consumer always ready
      for (int k = 0; k < N; k++) req_data[k*12 +: 12] = 12'(100 * k + 7);
      req_valid = '1; out_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         step();
         if (out_valid) ids.push_back(int'(out_id));
      end
      for (int i = 0; i < 6; i++) chk("rr_id", ids[i], rr_exp[i]);
      req_valid = '0;
      step(3);
      // backpressure in HOLD, then retire + accept on the same edge
      out_ready = 1'b0;
      req_valid[1] = 1'b1; req_data[12 +: 12] = 12'h155;
      step();
      req_valid[1] = 1'b0;
      req_valid[2] = 1'b1; req_data[24 +: 12] = 12'hE21;
      step();
      for (int c = 0; c < 5; c++) begin
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_ready", 32'(req_ready), 0);
         chk("bp_cvt_d", 32'(cvt_d), 12'h155);
         chk("bp_id", 32'(out_id), 1);
         step();
      end
      out_ready = 1'b1;
      #1 chk("bp_release_ready", 32'(req_ready), 4'b0100);
      step();
      req_valid = '0; out_ready = 1'b0;
      chk("bp_after_valid", 32'(out_valid), 0);
      chk("bp_after_cvt_d", 32'(cvt_d), 12'hE21);
      step();
      chk("bp_new_id", 32'(out_id), 2);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      // reset during CONV
      req_valid[3] = 1'b1;
      step();
      req_valid = '0; rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rconv_valid", 32'(out_valid), 0);
      chk("rconv_cvt_d", 32'(cvt_d), 0);
      chk("rconv_id", 32'(out_id), 0);
      // reset during HOLD, then grant restarts at requester 0
      req_valid[2] = 1'b1;
      step(2);
      req_valid = '0;
      chk("rhold_pre", 32'(out_valid), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rhold_valid", 32'(out_valid), 0);
      chk("rhold_sef", {out_s, out_e, out_f, out_id}, 0);
      req_valid = '1;
      #1 chk("rhold_grant", 32'(req_ready), 4'b0001);
      step();
      req_valid = '0;
      step();
      chk("rhold_id", 32'(out_id), 0);
      out_ready = 1'b1;
      step(2);
`ifdef FPCVT_STATS_EN
      rst = 1'b1; step(); rst = 1'b0; out_ready = 1'b0;
      single(0, 12'h7FF, 8'h7F);
      single(1, 12'h7FF, 8'h7F);
      single(2, 12'h001, 8'h01);
      single(3, 12'h7FF, 8'h7F);
      chk("sat_three", 32'(sat_count), 3);
`endif
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
